control_pipe_tracker: RTL and testbench

Pipelined consumer of the decoded control word produced in the ID stage. Carries the per-instruction control fields through EX, MEM and WB shadow registers and uses them to generate load-use stalls, operand forwarding selects and control-transfer flushes. Sits beside the ID/EX/MEM/WB datapath registers, between the control decoder and the PC/pipeline-register enables.

---
 rtl/control_pipe_tracker_pkg.sv | 25 ++
 rtl/control_pipe_stage.sv | 31 +++
 rtl/control_pipe_tracker.sv | 91 +++++++++
 tb/tb_control_pipe_tracker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/control_pipe_tracker_pkg.sv
// Shared types for the control pipe tracker: pc_action encodings, forward selects, stage record.
// Pure declarations; no timing or flow-control behaviour of its own.
package control_pipe_tracker_pkg;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2
    } pc_action_e;

    localparam logic [1:0] FWD_NONE  = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Address-width independent part of a stage record; the write address travels beside it.
    typedef struct packed {
        logic       valid;
        logic       writeEnable;
        logic       isLoad;
        pc_action_e pcAction;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_EMPTY = '{valid: 1'b0, writeEnable: 1'b0, isLoad: 1'b0, pcAction: PC_INC};

endpackage

// File: rtl/control_pipe_stage.sv
// One pipeline-stage control record register; a bubble loads an empty record.
// Latency 1 clock; no backpressure, advances every clock.
module control_pipe_stage
    import control_pipe_tracker_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bubble,
    input  stage_ctrl_t       ctrlIn,
    input  logic [ADDR_W-1:0] addrIn,
    output stage_ctrl_t       ctrlOut,
    output logic [ADDR_W-1:0] addrOut
);

    // A bubble clears the whole record so downstream never sees a stale address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrlOut <= STAGE_EMPTY;
            addrOut <= '0;
        end else if (bubble) begin
            ctrlOut <= STAGE_EMPTY;
            addrOut <= '0;
        end else begin
            ctrlOut <= ctrlIn;
            addrOut <= addrIn;
        end
    end

endmodule

// File: rtl/control_pipe_tracker.sv
// EX/MEM/WB control shadow: load-use/RAW stalls, forward selects, flushes; outputs combinational.
// CONTROL_PIPE_FORWARD_EN enables forwarding (1-cycle load-use stall), else RAW stall up to 2 cycles.
module control_pipe_tracker
    import control_pipe_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_reg_write_enable,
    input  logic                  id_write_data_memory,
    input  logic [REG_ADDR_W-1:0] id_write_addr,
    input  logic [REG_ADDR_W-1:0] id_reg1_addr,
    input  logic [REG_ADDR_W-1:0] id_reg2_addr,
    input  logic [1:0]            id_pc_action,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic [FWD_W-1:0]      fwd1_sel,
    output logic [FWD_W-1:0]      fwd2_sel,
    output logic                  wb_write_enable,
    output logic [REG_ADDR_W-1:0] wb_write_addr
);

    stage_ctrl_t idCtrl, exCtrl, memCtrl, wbCtrl;
    logic [REG_ADDR_W-1:0] exAddr, memAddr, wbAddr;
    logic exBubble, branchFlush, rawHazard;
    logic exHit1, exHit2, memHit1, memHit2;
    logic [1:0] fwd1Raw, fwd2Raw;
    logic unusedFields;

    function automatic logic writerMatch(stage_ctrl_t c, logic [REG_ADDR_W-1:0] a,
                                         logic [REG_ADDR_W-1:0] src);
        return c.valid && c.writeEnable && (a != '0) && (a == src);
    endfunction

    assign idCtrl = '{valid: id_valid, writeEnable: id_reg_write_enable,
                      isLoad: id_write_data_memory, pcAction: pc_action_e'(id_pc_action)};

    assign exBubble = stall | flush_id | ~id_valid;

    control_pipe_stage #(.ADDR_W(REG_ADDR_W)) u_ex (
        .clock(clock), .reset(reset), .bubble(exBubble),
        .ctrlIn(idCtrl), .addrIn(id_write_addr), .ctrlOut(exCtrl), .addrOut(exAddr));

    control_pipe_stage #(.ADDR_W(REG_ADDR_W)) u_mem (
        .clock(clock), .reset(reset), .bubble(1'b0),
        .ctrlIn(exCtrl), .addrIn(exAddr), .ctrlOut(memCtrl), .addrOut(memAddr));

    control_pipe_stage #(.ADDR_W(REG_ADDR_W)) u_wb (
        .clock(clock), .reset(reset), .bubble(1'b0),
        .ctrlIn(memCtrl), .addrIn(memAddr), .ctrlOut(wbCtrl), .addrOut(wbAddr));

    assign exHit1  = writerMatch(exCtrl, exAddr, id_reg1_addr);
    assign exHit2  = writerMatch(exCtrl, exAddr, id_reg2_addr);
    assign memHit1 = writerMatch(memCtrl, memAddr, id_reg1_addr);
    assign memHit2 = writerMatch(memCtrl, memAddr, id_reg2_addr);

    assign branchFlush = ex_branch_taken && exCtrl.valid && (exCtrl.pcAction == PC_BRANCH);

`ifdef CONTROL_PIPE_FORWARD_EN
    assign rawHazard = id_valid && exCtrl.isLoad && (exHit1 || exHit2);
    assign fwd1Raw   = exHit1 ? FWD_EXMEM : (memHit1 ? FWD_MEMWB : FWD_NONE);
    assign fwd2Raw   = exHit2 ? FWD_EXMEM : (memHit2 ? FWD_MEMWB : FWD_NONE);
`else
    // WB is covered by the register file writing before it reads.
    assign rawHazard = id_valid && (exHit1 || exHit2 || memHit1 || memHit2);
    assign fwd1Raw   = FWD_NONE;
    assign fwd2Raw   = FWD_NONE;
`endif

    // Outputs are forced quiet while reset is held, regardless of what ID presents.
    always_comb begin
        stall    = ~reset & rawHazard & ~branchFlush;
        flush_id = ~reset & branchFlush;
        flush_if = ~reset & (branchFlush |
                   (id_valid & (pc_action_e'(id_pc_action) == PC_JUMP) & ~stall));
        fwd1_sel = reset ? '0 : FWD_W'(fwd1Raw);
        fwd2_sel = reset ? '0 : FWD_W'(fwd2Raw);
    end

    assign wb_write_enable = wbCtrl.valid & wbCtrl.writeEnable & (wbAddr != '0);
    assign wb_write_addr   = wbAddr;

    assign unusedFields = ^{exCtrl.isLoad, memCtrl.isLoad, memCtrl.pcAction,
                            wbCtrl.isLoad, wbCtrl.pcAction};

endmodule

// File: tb/tb_control_pipe_tracker.sv
// Directed plus random stimulus against an instruction-history reference model.
module tb_control_pipe_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_reg_write_enable, id_write_data_memory, ex_branch_taken;
    logic [4:0] id_write_addr, id_reg1_addr, id_reg2_addr, wb_write_addr;
    logic [1:0] id_pc_action, fwd1_sel, fwd2_sel;
    logic       stall, flush_if, flush_id, wb_write_enable;

    always #5 clock = ~clock;

    control_pipe_tracker #(.REG_ADDR_W(5), .FWD_W(2)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_reg_write_enable(id_reg_write_enable),
        .id_write_data_memory(id_write_data_memory), .id_write_addr(id_write_addr),
        .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
        .id_pc_action(id_pc_action), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush_if(flush_if), .flush_id(flush_id),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr));

    typedef struct {
        bit valid;
        bit we;
        bit load;
        int waddr;
        int pca;
    } instr_t;

    // Instructions that left ID: [0] in EX, [1] in MEM, [2] in WB.
    instr_t pipe[3];
    int checks = 0;
    int errors = 0;
    bit eStall, eFlushIf, eFlushId;
    int eFwd1, eFwd2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes(instr_t r, int src);
        return r.valid && r.we && r.waddr != 0 && r.waddr == src;
    endfunction

    function automatic int fwdFor(int src);
        if (writes(pipe[0], src)) return 1;
        if (writes(pipe[1], src)) return 2;
        return 0;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
    endtask

    task automatic drive(input bit v, we, ld, input int wa, r1, r2, pca, input bit bt);
        id_valid = v; id_reg_write_enable = we; id_write_data_memory = ld;
        id_write_addr = 5'(wa); id_reg1_addr = 5'(r1); id_reg2_addr = 5'(r2);
        id_pc_action = 2'(pca); ex_branch_taken = bt;
    endtask

    task automatic predict();
        bit brFlush, hazard;
        int r1, r2;
        r1 = int'(id_reg1_addr);
        r2 = int'(id_reg2_addr);
        brFlush = ex_branch_taken && pipe[0].valid && pipe[0].pca == 2;
`ifdef CONTROL_PIPE_FORWARD_EN
        hazard = id_valid && pipe[0].load && (writes(pipe[0], r1) || writes(pipe[0], r2));
        eFwd1 = fwdFor(r1);
        eFwd2 = fwdFor(r2);
`else
        hazard = id_valid && (writes(pipe[0], r1) || writes(pipe[0], r2) ||
                              writes(pipe[1], r1) || writes(pipe[1], r2));
        eFwd1 = 0;
        eFwd2 = 0;
`endif
        eStall   = hazard && !brFlush;
        eFlushId = brFlush;
        eFlushIf = brFlush || (id_valid && id_pc_action == 2'd1 && !eStall);
    endtask

    task automatic checkOutputs();
        predict();
        chk("stall", 32'(stall), 32'(eStall));
        chk("flush_if", 32'(flush_if), 32'(eFlushIf));
        chk("flush_id", 32'(flush_id), 32'(eFlushId));
        chk("fwd1_sel", 32'(fwd1_sel), 32'(eFwd1));
        chk("fwd2_sel", 32'(fwd2_sel), 32'(eFwd2));
        chk("wb_write_enable", 32'(wb_write_enable),
            32'(pipe[2].valid && pipe[2].we && pipe[2].waddr != 0));
        if (pipe[2].valid) chk("wb_write_addr", 32'(wb_write_addr), 32'(pipe[2].waddr));
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_flush_if"}, 32'(flush_if), 0);
        chk({tag, "_flush_id"}, 32'(flush_id), 0);
        chk({tag, "_fwd1"}, 32'(fwd1_sel), 0);
        chk({tag, "_fwd2"}, 32'(fwd2_sel), 0);
        chk({tag, "_wb_we"}, 32'(wb_write_enable), 0);
        chk({tag, "_wb_addr"}, 32'(wb_write_addr), 0);
    endtask

    task automatic cycle(input bit v, we, ld, input int wa, r1, r2, pca, input bit bt);
        instr_t nx;
        drive(v, we, ld, wa, r1, r2, pca, bt);
        #1;
        checkOutputs();
        nx = '{0, 0, 0, 0, 0};
        if (v && !eStall && !eFlushId) nx = '{v, we, ld, wa, pca};
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nx;
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 1, 0, 8, 8, 9, 1, 1);
        clearModel();
        #3;
        checkReset("reset");
        #9 reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;

        // lw $t0 ; add $t2,$t0 (repeat while held) ; drain to WB
        cycle(1, 1, 1, 8, 0, 0, 0, 0);
        repeat (3) cycle(1, 1, 0, 10, 8, 0, 0, 0);
        repeat (4) nop();

        // add $t1 ; sub reading $t1 in rt, back to back and with a gap
        cycle(1, 1, 0, 9, 1, 2, 0, 0);
        repeat (3) cycle(1, 1, 0, 11, 3, 9, 0, 0);
        repeat (3) nop();
        cycle(1, 1, 0, 9, 1, 2, 0, 0);
        nop();
        repeat (2) cycle(1, 1, 0, 11, 3, 9, 0, 0);
        repeat (3) nop();

        // writer to $zero then reader of $zero
        cycle(1, 1, 0, 0, 1, 2, 0, 0);
        cycle(1, 1, 0, 12, 0, 0, 0, 0);
        repeat (4) nop();

        // writer, taken branch, reader: branch flush overrides any stall
        cycle(1, 1, 1, 10, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 2, 0);
        cycle(1, 1, 0, 11, 10, 10, 0, 1);
        repeat (4) nop();

        // jump reading a just-loaded register: no flush until the stall clears
        cycle(1, 1, 1, 8, 0, 0, 0, 0);
        repeat (2) cycle(1, 0, 0, 0, 8, 0, 1, 0);
        repeat (4) nop();

        // reset asserted while a load-use stall is showing
        cycle(1, 1, 1, 8, 0, 0, 0, 0);
        drive(1, 1, 0, 10, 8, 8, 0, 0);
        #1;
        checkOutputs();
        #2 reset = 1'b1;
        #1;
        checkReset("midstall");
        clearModel();
        @(posedge clock);
        #3 reset = 1'b0;
        cycle(1, 1, 0, 10, 8, 8, 0, 0);
        nop();

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
